// File: rtl/tlp_tx_arbiter.sv
// Merges NUM_CHAN TLP sources onto one stream with packet-locked round-robin arbitration,
// a 2-entry output skid buffer, and a saturating counter of discarded SOP-less idle beats.
module tlp_tx_arbiter #(
  parameter int NUM_CHAN   = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                           pcieClk_in,
  input  logic                           reset_in,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] chanData_in,
  input  logic [NUM_CHAN-1:0]            chanSOP_in,
  input  logic [NUM_CHAN-1:0]            chanEOP_in,
  input  logic [NUM_CHAN-1:0]            chanValid_in,
  output logic [NUM_CHAN-1:0]            chanReady_out,
  output logic [DATA_WIDTH-1:0]          txData_out,
  output logic                           txSOP_out,
  output logic                           txEOP_out,
  output logic                           txValid_out,
  input  logic                           txReady_in,
  output logic [NUM_CHAN-1:0]            grant_out,
  output logic [15:0]                    errCount_out
);
  localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       lock_ch_q, lock_ch_d, last_q, last_d;
  logic [CW-1:0]       sel_ch, idx_c, orph_ch;
  logic [1:0]          occ_q, occ_d;
  logic                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, live_q, live_d;
  logic [EW-1:0]       mem_q [2];
  logic [EW-1:0]       mem_d [2];
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [NUM_CHAN-1:0] ready, grant;
  logic                buf_rdy, sel_vld, found, orph_vld, push, pop;
  logic [EW-1:0]       push_ent;
  int                  idx;

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    last_d    = last_q;
    occ_d     = occ_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    mem_d     = mem_q;
    err_cnt_d = err_cnt_q;
    live_d    = 1'b1;
    ready     = '0;
    grant     = '0;
    sel_ch    = '0;
    sel_vld   = 1'b0;
    found     = 1'b0;
    orph_ch   = '0;
    orph_vld  = 1'b0;
    idx       = 0;
    idx_c     = '0;
    // Buffer space is judged on registered occupancy only, so a full buffer never accepts
    buf_rdy   = (occ_q != 2'd2);

    // live_q holds off accepts until the second edge after reset release
    if (live_q) begin
      if (state_q == LOCKED) begin
        sel_ch  = lock_ch_q;
        sel_vld = 1'b1;
      end else begin
        for (int off = 1; off <= NUM_CHAN; off++) begin
          idx = int'(last_q) + off;
          if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
          idx_c = CW'(idx);
          if (!found && chanValid_in[idx_c] && chanSOP_in[idx_c]) begin
            found  = 1'b1;
            sel_ch = idx_c;
          end
        end
        sel_vld = found;
        if (!found) begin
          for (int c = NUM_CHAN - 1; c >= 0; c--) begin
            if (chanValid_in[CW'(c)]) begin
              orph_vld = 1'b1;
              orph_ch  = CW'(c);
            end
          end
        end
      end
    end

    if (sel_vld) ready[sel_ch] = buf_rdy;
    if (orph_vld) begin
      ready[orph_ch] = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    push     = sel_vld & buf_rdy & chanValid_in[sel_ch];
    push_ent = {chanSOP_in[sel_ch], chanEOP_in[sel_ch],
                chanData_in[int'(sel_ch)*DATA_WIDTH +: DATA_WIDTH]};
    pop      = (occ_q != 2'd0) & txReady_in;

    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = ~wr_ptr_q;
      if (state_q == IDLE) begin
        if (chanEOP_in[sel_ch]) begin
          last_d = sel_ch;
        end else begin
          state_d   = LOCKED;
          lock_ch_d = sel_ch;
        end
      end else if (chanEOP_in[sel_ch]) begin
        state_d = IDLE;
        last_d  = lock_ch_q;
      end
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (state_q == LOCKED) grant[lock_ch_q] = 1'b1;
  end

  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      last_q    <= CW'(NUM_CHAN - 1);
      occ_q     <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      live_q    <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      last_q    <= last_d;
      occ_q     <= occ_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      live_q    <= live_d;
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      err_cnt_q <= err_cnt_d;
    end
  end

  assign chanReady_out = ready;
  assign grant_out     = grant;
  assign errCount_out  = err_cnt_q;
  assign txValid_out   = (occ_q != 2'd0);
  assign txData_out    = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign txSOP_out     = txValid_out & mem_q[rd_ptr_q][EW-1];
  assign txEOP_out     = txValid_out & mem_q[rd_ptr_q][EW-2];

endmodule
